// File: rtl/reset_seq_pkg.sv
// Shared constants for the board reset sequencer.
// State encodings, reset-cause codes and a counter-width helper.
package reset_seq_pkg;

    typedef logic [1:0] cause_t;

    localparam logic [2:0] ST_ASSERT = 3'd0;
    localparam logic [2:0] ST_HOLD   = 3'd1;
    localparam logic [2:0] ST_MEM_UP = 3'd2;
    localparam logic [2:0] ST_PER_UP = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    localparam cause_t CAUSE_NONE = 2'b00;
    localparam cause_t CAUSE_POR  = 2'b01;
    localparam cause_t CAUSE_BTN  = 2'b10;
    localparam cause_t CAUSE_WDT  = 2'b11;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// Push-button synchroniser and debouncer.
// The level flips after DEBOUNCE_CYCLES consecutive differing samples.
module reset_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic btn_level,
    output logic pressed
);
    import reset_seq_pkg::*;

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          cnt;
    logic                   sampled;

    assign sampled = sync[SYNC_STAGES-1];
    assign pressed = ~btn_level;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync      <= '1;
            cnt       <= '0;
            btn_level <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_n};
            if (sampled == btn_level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                btn_level <= sampled;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: releases memory, peripherals, then CPU in order.
// Optional watchdog trip enabled by defining WATCHDOG_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 1000,
    parameter int STAGE_GAP       = 16,
    parameter int WDT_CYCLES      = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       wdt_kick,
    output logic       mem_rst_n,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       rst_busy,
    output logic       led,
    output logic [1:0] reset_cause
);
    import reset_seq_pkg::*;

    localparam int SEQ_MAX =
        (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW = cnt_width(SEQ_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    cause_t        cause_n;
    logic          pressed;
    logic          trip;
    logic          unused_btn_level;

    reset_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .btn_level(unused_btn_level),
        .pressed  (pressed)
    );

`ifdef WATCHDOG_EN
    localparam int WW = cnt_width(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt;

    // A kick in the timeout cycle suppresses the trip.
    assign trip = (state == ST_RUN) && (wdt == WDT_LAST) && !wdt_kick;

    always_ff @(posedge clk) begin
        if (!reset || state != ST_RUN || wdt_kick) begin
            wdt <= '0;
        end else if (wdt != WDT_LAST) begin
            wdt <= wdt + 1'b1;
        end
    end
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_wdt_kick;

    assign unused_wdt_kick = wdt_kick;
    assign trip            = 1'b0;
`endif

    // Button beats watchdog when both fire together.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cause_n = reset_cause;
        if (pressed && state != ST_ASSERT) begin
            state_n = ST_ASSERT;
            cnt_n   = '0;
            cause_n = CAUSE_BTN;
        end else if (trip) begin
            state_n = ST_ASSERT;
            cnt_n   = '0;
            cause_n = CAUSE_WDT;
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    cnt_n = '0;
                    if (!pressed) state_n = ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_n = ST_MEM_UP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_MEM_UP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = ST_PER_UP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_PER_UP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = ST_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_n = '0;
                end
                default: begin
                    state_n = ST_ASSERT;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change with the state flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_ASSERT;
            cnt          <= '0;
            reset_cause  <= CAUSE_POR;
            mem_rst_n    <= 1'b0;
            periph_rst_n <= 1'b0;
            cpu_rst_n    <= 1'b0;
            rst_busy     <= 1'b1;
            led          <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            reset_cause  <= cause_n;
            mem_rst_n    <= state_n inside {ST_MEM_UP, ST_PER_UP, ST_RUN};
            periph_rst_n <= state_n inside {ST_PER_UP, ST_RUN};
            cpu_rst_n    <= (state_n == ST_RUN);
            rst_busy     <= (state_n != ST_RUN);
            led          <= (state_n != ST_RUN);
        end
    end

endmodule
